// File: rtl/nes_pad_reader.sv
// Host-side reader for a native NES joypad (4021): drives LATCH/CLK, shifts in
// eight active-low button bits and presents them active-high with a valid strobe.
module nes_pad_reader #(
   parameter int unsigned LATCH_CYC = 21,
   parameter int unsigned HALF_CYC  = 11,
   parameter int unsigned POLL_CYC  = 29781
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       start,
   input  logic       auto_en,
   input  logic       pad_data,
   output logic       pad_latch,
   output logic       pad_clk,
   output logic [7:0] buttons,
   output logic       valid,
   output logic       busy
);

   localparam int unsigned CNT_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned POLL_W  = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;

   localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYC - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_CYC - 1);
   localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LATCH = 2'd1,
      S_LOW   = 2'd2,
      S_HIGH  = 2'd3
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_idx;
   logic [6:0]        r_shift;
   logic [7:0]        r_buttons;
   logic              r_valid;
   logic              r_pad_latch;
   logic              r_pad_clk;
   logic              r_busy;
   logic              r_pending;
   logic [POLL_W-1:0] r_poll;
   logic              r_sync1;
   logic              r_sync2;

   state_t            w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [2:0]        w_idx_nxt;
   logic [6:0]        w_shift_nxt;
   logic [7:0]        w_buttons_nxt;
   logic              w_valid_nxt;
   logic              w_latch_nxt;
   logic              w_clk_nxt;
   logic              w_busy_nxt;
   logic              w_pending_nxt;
   logic              w_wrap;
   logic              w_wrap_req;

   // Two-flop synchronizer for the asynchronous pad serial line; idles high (released).
   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= pad_data;
         r_sync2 <= r_sync1;
      end
   end

   // Free-running frame timer; a wrap requests a poll only while auto_en is set.
   assign w_wrap     = (r_poll == POLL_LAST);
   assign w_wrap_req = w_wrap & auto_en;

   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_poll <= '0;
      end else if (w_wrap) begin
         r_poll <= '0;
      end else begin
         r_poll <= r_poll + POLL_W'(1);
      end
   end

   // State and registered-output flops.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_idx       <= 3'd0;
         r_shift     <= 7'd0;
         r_buttons   <= 8'h00;
         r_valid     <= 1'b0;
         r_pad_latch <= 1'b0;
         r_pad_clk   <= 1'b1;
         r_busy      <= 1'b0;
         r_pending   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_idx       <= w_idx_nxt;
         r_shift     <= w_shift_nxt;
         r_buttons   <= w_buttons_nxt;
         r_valid     <= w_valid_nxt;
         r_pad_latch <= w_latch_nxt;
         r_pad_clk   <= w_clk_nxt;
         r_busy      <= w_busy_nxt;
         r_pending   <= w_pending_nxt;
      end
   end

   // Next-state logic; outputs are decoded from the next state so they register in step.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_shift_nxt   = r_shift;
      w_buttons_nxt = r_buttons;
      w_valid_nxt   = 1'b0;
      w_pending_nxt = r_pending | w_wrap_req;

      case (r_state)
         S_IDLE: begin
            // Accepting a request consumes any wrap on the same edge, so they merge.
            if (start || r_pending) begin
               w_state_nxt   = S_LATCH;
               w_cnt_nxt     = '0;
               w_pending_nxt = 1'b0;
            end
         end
         S_LATCH: begin
            if (r_cnt == LATCH_LAST) begin
               w_shift_nxt = {r_sync2, r_shift[6:1]};
               w_idx_nxt   = 3'd1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_LOW;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_LOW: begin
            if (r_cnt == HALF_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_HIGH;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (r_cnt == HALF_LAST) begin
               w_cnt_nxt = '0;
               if (r_idx == 3'd7) begin
                  // Bits arrive LSB first; the eighth bit bypasses the shifter.
                  w_buttons_nxt = ~{r_sync2, r_shift};
                  w_valid_nxt   = 1'b1;
                  w_state_nxt   = S_IDLE;
               end else begin
                  w_shift_nxt = {r_sync2, r_shift[6:1]};
                  w_idx_nxt   = r_idx + 3'd1;
                  w_state_nxt = S_LOW;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_latch_nxt = (w_state_nxt == S_LATCH);
      w_clk_nxt   = (w_state_nxt != S_LOW);
      w_busy_nxt  = (w_state_nxt != S_IDLE);
   end

   assign pad_latch = r_pad_latch;
   assign pad_clk   = r_pad_clk;
   assign buttons   = r_buttons;
   assign valid     = r_valid;
   assign busy      = r_busy;

endmodule
